// File: rtl/rggen_host_arbiter_pkg.sv
// Shared types for the register-bus host arbiter.
package rggen_host_arbiter_pkg;

  // Arbiter control flow: pick a host, run one bus access, pulse its ack.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // Completion status of a single bus access.
  typedef enum logic {
    STATUS_OK    = 1'b0,
    STATUS_ERROR = 1'b1
  } access_status_e;

  localparam int MAX_HOSTS = 8;

endpackage

// File: rtl/rggen_host_arbiter_round_robin.sv
// Round-robin selector: the lowest requesting host at or above the pointer
// wins; if none sits at or above it, the search wraps to host 0.
module rggen_round_robin_arbiter #(
  parameter int HOSTS = 2,
  parameter int PTR_W = (HOSTS > 1) ? $clog2(HOSTS) : 1
) (
  input  logic [HOSTS-1:0] request,
  input  logic [PTR_W-1:0] pointer,
  output logic [HOSTS-1:0] grant
);

  logic [HOSTS-1:0] upper_mask;
  logic [HOSTS-1:0] upper_req;

  // Hosts at or above the pointer get first pick.
  assign upper_mask = ~((HOSTS'(1) << pointer) - HOSTS'(1));
  assign upper_req  = request & upper_mask;

  // Isolate the lowest set bit of the chosen search window.
  always_comb begin
    if (|upper_req) grant = upper_req & (~upper_req + HOSTS'(1));
    else            grant = request & (~request + HOSTS'(1));
  end

endmodule

// File: rtl/rggen_host_arbiter.sv
// Multi-host register-bus arbiter: one access in flight at a time, hosts
// granted round-robin, single-cycle ack back to the winner.
// Optional feature: define RGGEN_HOST_ARBITER_TIMEOUT_EN to abort accesses
// that wait TIMEOUT_CYCLES without i_bus_ready (reported as an error).
module rggen_host_arbiter
  import rggen_host_arbiter_pkg::*;
#(
  parameter int HOSTS          = 2,
  parameter int ADDRESS_WIDTH  = 7,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [HOSTS-1:0]                    i_request,
  input  logic [HOSTS-1:0]                    i_write,
  input  logic [HOSTS-1:0][ADDRESS_WIDTH-1:0] i_address,
  input  logic [HOSTS-1:0][DATA_WIDTH-1:0]    i_write_data,
  output logic [HOSTS-1:0]                    o_ack,
  output logic [DATA_WIDTH-1:0]               o_read_data,
  output logic                                o_error,
  output logic                                o_bus_valid,
  output logic                                o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]            o_bus_address,
  output logic [DATA_WIDTH-1:0]               o_bus_write_data,
  input  logic                                i_bus_ready,
  input  logic [DATA_WIDTH-1:0]               i_bus_read_data,
  input  logic                                i_bus_error
);

  localparam int PTR_W = (HOSTS > 1) ? $clog2(HOSTS) : 1;

  state_e         state;
  logic [PTR_W-1:0] pointer;
  logic [PTR_W-1:0] win_idx;
  logic [HOSTS-1:0] grant;
  logic [PTR_W-1:0] grant_idx;
  access_status_e bus_status;

`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer;
`endif

  rggen_round_robin_arbiter #(
    .HOSTS (HOSTS),
    .PTR_W (PTR_W)
  ) u_rr (
    .request (i_request),
    .pointer (pointer),
    .grant   (grant)
  );

  // One-hot grant to a host index for field muxing.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < HOSTS; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

  assign bus_status = i_bus_error ? STATUS_ERROR : STATUS_OK;

  // Arbiter FSM; every host- and bus-facing output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pointer          <= '0;
      win_idx          <= '0;
      o_ack            <= '0;
      o_read_data      <= '0;
      o_error          <= 1'b0;
      o_bus_valid      <= 1'b0;
      o_bus_write      <= 1'b0;
      o_bus_address    <= '0;
      o_bus_write_data <= '0;
`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
      timer            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_ack <= '0;
          if (|i_request) begin
            win_idx          <= grant_idx;
            o_bus_valid      <= 1'b1;
            o_bus_write      <= i_write[grant_idx];
            o_bus_address    <= i_address[grant_idx];
            // Reads carry no payload on the bus.
            o_bus_write_data <= i_write[grant_idx] ? i_write_data[grant_idx] : '0;
            state            <= ACCESS;
          end
        end

        ACCESS: begin
          if (i_bus_ready) begin
            o_ack            <= HOSTS'(1) << win_idx;
            o_error          <= (bus_status == STATUS_ERROR);
            // Writes and failed accesses return no data.
            o_read_data      <= (bus_status == STATUS_OK && !o_bus_write) ? i_bus_read_data : '0;
            o_bus_valid      <= 1'b0;
            o_bus_write      <= 1'b0;
            o_bus_address    <= '0;
            o_bus_write_data <= '0;
`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
            timer            <= '0;
`endif
            state            <= RESPOND;
          end
`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
          else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Bus never answered: give up and report an error.
            o_ack            <= HOSTS'(1) << win_idx;
            o_error          <= 1'b1;
            o_read_data      <= '0;
            o_bus_valid      <= 1'b0;
            o_bus_write      <= 1'b0;
            o_bus_address    <= '0;
            o_bus_write_data <= '0;
            timer            <= '0;
            state            <= RESPOND;
          end else begin
            timer <= timer + TMR_W'(1);
          end
`endif
        end

        RESPOND: begin
          // Ack is a one-cycle pulse; requests seen now wait for IDLE.
          o_ack       <= '0;
          o_read_data <= '0;
          o_error     <= 1'b0;
          pointer     <= (win_idx == PTR_W'(HOSTS - 1)) ? '0 : win_idx + PTR_W'(1);
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Directed bench for rggen_host_arbiter with a scoreboard of expected acks.
module tb_rggen_host_arbiter;

  localparam int HOSTS = 2;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int TO    = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [HOSTS-1:0]        i_request;
  logic [HOSTS-1:0]        i_write;
  logic [HOSTS-1:0][AW-1:0] i_address;
  logic [HOSTS-1:0][DW-1:0] i_write_data;
  logic [HOSTS-1:0]        o_ack;
  logic [DW-1:0]           o_read_data;
  logic                    o_error;
  logic                    o_bus_valid;
  logic                    o_bus_write;
  logic [AW-1:0]           o_bus_address;
  logic [DW-1:0]           o_bus_write_data;
  logic                    i_bus_ready;
  logic [DW-1:0]           i_bus_read_data;
  logic                    i_bus_error;

  typedef struct {
    int          host;
    logic [DW-1:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rggen_host_arbiter #(
    .HOSTS(HOSTS), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_request(i_request), .i_write(i_write),
    .i_address(i_address), .i_write_data(i_write_data),
    .o_ack(o_ack), .o_read_data(o_read_data), .o_error(o_error),
    .o_bus_valid(o_bus_valid), .o_bus_write(o_bus_write),
    .o_bus_address(o_bus_address), .o_bus_write_data(o_bus_write_data),
    .i_bus_ready(i_bus_ready), .i_bus_read_data(i_bus_read_data),
    .i_bus_error(i_bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int h, input logic [DW-1:0] d, input logic e);
    exp_t x;
    x.host = h; x.rdata = d; x.err = e;
    sb.push_back(x);
  endtask

  task automatic host(input int h, input logic req, input logic wr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    i_request[h]    = req;
    i_write[h]      = wr;
    i_address[h]    = a;
    i_write_data[h] = d;
  endtask

  task automatic bus(input logic rdy, input logic [DW-1:0] d, input logic e);
    i_bus_ready     = rdy;
    i_bus_read_data = d;
    i_bus_error     = e;
  endtask

  // Compare the ack currently on the outputs against the scoreboard head.
  task automatic check_ack(input string tag);
    exp_t e;
    logic [HOSTS-1:0] v;
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      v = '0;
      v[e.host] = 1'b1;
      chk({tag, "_ack"},   64'(o_ack),       64'(v));
      chk({tag, "_rdata"}, 64'(o_read_data), 64'(e.rdata));
      chk({tag, "_err"},   64'(o_error),     64'(e.err));
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    repeat (budget) begin
      @(negedge clk);
      if (o_ack != '0) break;
    end
    chk({tag, "_arrived"}, 64'(o_ack != '0), 64'd1);
    if (o_ack != '0) check_ack(tag);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    repeat (budget) begin
      @(negedge clk);
      if (o_bus_valid) break;
    end
    chk({tag, "_valid"}, 64'(o_bus_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    i_request = '0; i_write = '0; i_address = '0; i_write_data = '0;
    bus(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ack",    64'(o_ack),            64'd0);
    chk("rst_valid",  64'(o_bus_valid),      64'd0);
    chk("rst_bus",    64'({o_bus_write, o_bus_address, o_bus_write_data}), 64'd0);
    chk("rst_rdata",  64'({o_read_data, o_error}), 64'd0);
    rst = 1'b0;

    // Single host read at minimum latency.
    host(0, 1'b1, 1'b0, 7'h04, 32'h0);
    push(0, 32'h12345678, 1'b0);
    @(negedge clk);
    chk("t1_valid", 64'(o_bus_valid), 64'd1);
    chk("t1_addr",  64'(o_bus_address), 64'h04);
    chk("t1_wr",    64'({o_bus_write, o_bus_write_data}), 64'd0);
    bus(1'b1, 32'h12345678, 1'b0);
    @(negedge clk);
    check_ack("t1");
    chk("t1_valid_drop", 64'(o_bus_valid), 64'd0);
    host(0, 1'b0, 1'b0, 7'h0, 32'h0);

    // Host 1 write raised during RESPOND; read data must come back zero.
    host(1, 1'b1, 1'b1, 7'h0C, 32'hA5A5A5A5);
    bus(1'b1, 32'hAAAA5555, 1'b0);
    push(1, 32'h0, 1'b0);
    wait_ack("t2", 8);
    host(1, 1'b0, 1'b0, 7'h0, 32'h0);
    bus(1'b0, '0, 1'b0);

    // Contention: order 0,1,0,1.
    host(0, 1'b1, 1'b0, 7'h10, 32'h0);
    host(1, 1'b1, 1'b0, 7'h14, 32'h0);
    bus(1'b1, 32'hCAFEF00D, 1'b0);
    push(0, 32'hCAFEF00D, 1'b0);
    push(1, 32'hCAFEF00D, 1'b0);
    push(0, 32'hCAFEF00D, 1'b0);
    push(1, 32'hCAFEF00D, 1'b0);
    for (int k = 0; k < 4; k++) wait_ack("t3", 8);
    i_request = '0;
    bus(1'b0, '0, 1'b0);

    // Stall: five cycles without ready, fields held stable.
    host(0, 1'b1, 1'b1, 7'h20, 32'h11223344);
    push(0, 32'h0, 1'b0);
    wait_valid("t4", 8);
    for (int k = 0; k < 5; k++) begin
      chk("t4_hold", 64'({o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data}),
          64'({1'b1, 1'b1, 7'h20, 32'h11223344}));
      chk("t4_noack", 64'(o_ack), 64'd0);
      if (k < 4) @(negedge clk);
    end
    bus(1'b1, 32'h99999999, 1'b0);
    wait_ack("t4", 2);
    host(0, 1'b0, 1'b0, 7'h0, 32'h0);
    bus(1'b0, '0, 1'b0);

    // Bus error on a write.
    host(1, 1'b1, 1'b1, 7'h08, 32'hDEADBEEF);
    push(1, 32'h0, 1'b1);
    wait_valid("t5", 8);
    chk("t5_bus", 64'({o_bus_write, o_bus_address, o_bus_write_data}),
        64'({1'b1, 7'h08, 32'hDEADBEEF}));
    bus(1'b1, 32'h55555555, 1'b1);
    wait_ack("t5", 2);
    host(1, 1'b0, 1'b0, 7'h0, 32'h0);
    bus(1'b0, '0, 1'b0);

    // Request dropped mid-access still completes.
    host(0, 1'b1, 1'b0, 7'h30, 32'h0);
    push(0, 32'h0F0F0F0F, 1'b0);
    wait_valid("t6", 8);
    host(0, 1'b0, 1'b0, 7'h30, 32'h0);
    @(negedge clk);
    chk("t6_still_valid", 64'(o_bus_valid), 64'd1);
    bus(1'b1, 32'h0F0F0F0F, 1'b0);
    wait_ack("t6", 2);
    bus(1'b0, '0, 1'b0);

    // Reset mid-access: no ack, pointer back to host 0.
    host(0, 1'b1, 1'b0, 7'h40, 32'h0);
    wait_valid("t7", 8);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_valid_drop", 64'(o_bus_valid), 64'd0);
    chk("t7_noack",      64'(o_ack),       64'd0);
    rst = 1'b0;
    host(1, 1'b1, 1'b0, 7'h44, 32'h0);
    bus(1'b1, 32'h13579BDF, 1'b0);
    push(0, 32'h13579BDF, 1'b0);
    wait_ack("t7", 6);
    i_request = '0;
    bus(1'b0, '0, 1'b0);

    // Bus never answers.
    host(1, 1'b1, 1'b0, 7'h50, 32'h0);
    wait_valid("t8", 8);
`ifdef RGGEN_HOST_ARBITER_TIMEOUT_EN
    push(1, 32'h0, 1'b1);
    bus(1'b0, 32'h77777777, 1'b0);
    n = 1;
    repeat (40) begin
      @(negedge clk);
      if (o_ack != '0) break;
      n++;
    end
    chk("t8_cycles", 64'(n), 64'(TO));
    check_ack("t8");
`else
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_bus_valid && o_ack == '0) n++;
    end
    chk("t8_waits", 64'(n), 64'd20);
    push(1, 32'h2468ACE0, 1'b0);
    bus(1'b1, 32'h2468ACE0, 1'b0);
    wait_ack("t8", 2);
`endif
    i_request = '0;
    bus(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
